line_rasterizer: RTL and testbench

- Bresenham line engine directly downstream of the core control unit.
- Accepts one line primitive (two endpoints) per start pulse and walks every pixel from endpoint 0 to endpoint 1, inclusive.
- Pushes each pixel coordinate into the pixel FIFO through a valid/ready handshake.
- Returns a one-cycle ldone pulse that drives the control unit's LMAKEL/TRIMAKELn exit transitions.

---
 rtl/line_rasterizer.sv | 159 +++++++++++++++
 tb/tb_line_rasterizer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_rasterizer.sv
// rtl/line_rasterizer.sv - Bresenham line walker feeding the pixel FIFO with a one-cycle ldone pulse.
// Optional screen clipping is compiled in with `define LINE_CLIP_EN.
module line_rasterizer #(
    parameter int COORD_W  = 10,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               start,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               busy,
    output logic               ldone
);
    localparam int EW = COORD_W + 3;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);
    localparam logic signed [EW-1:0] ZERO = '0;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic [COORD_W-1:0] x1_q, x1_d, y1_q, y1_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

    logic [COORD_W-1:0] adx, ady;
    logic signed [EW-1:0] setup_dx, setup_dy;
    logic signed [EW:0] e2, dx_w, dy_w;
    logic step_x, step_y, at_end, on_screen, advance;

    assign adx = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    assign ady = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    assign setup_dx = $signed({3'b000, adx});
    assign setup_dy = -$signed({3'b000, ady});

    // Decision terms use the pre-update error so both axes step off the same value.
    assign e2     = $signed({err_q, 1'b0});
    assign dx_w   = $signed({dx_q[EW-1], dx_q});
    assign dy_w   = $signed({dy_q[EW-1], dy_q});
    assign step_x = (e2 >= dy_w);
    assign step_y = (e2 <= dx_w);
    assign at_end = (cur_x_q == x1_q) && (cur_y_q == y1_q);

`ifdef LINE_CLIP_EN
    assign on_screen = ({1'b0, cur_x_q} < (COORD_W+1)'(SCREEN_W)) &&
                       ({1'b0, cur_y_q} < (COORD_W+1)'(SCREEN_H));
    // Off-screen points are skipped without waiting on the FIFO.
    assign advance   = (state_q == S_RUN) && (!on_screen || pix_ready);
`else
    logic unused_screen;
    assign unused_screen = (SCREEN_W == 0) || (SCREEN_H == 0);
    assign on_screen     = 1'b1;
    assign advance       = (state_q == S_RUN) && pix_ready;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                dx_d     = setup_dx;
                dy_d     = setup_dy;
                err_d    = setup_dx + setup_dy;
                sx_neg_d = !(x0_q < x1_q);
                sy_neg_d = !(y0_q < y1_q);
                cur_x_d  = x0_q;
                cur_y_d  = y0_q;
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (advance) begin
                    if (at_end) begin
                        state_d = S_DONE;
                    end else begin
                        err_d = err_q + (step_x ? dy_q : ZERO) + (step_y ? dx_q : ZERO);
                        if (step_x) begin
                            cur_x_d = sx_neg_q ? (cur_x_q - ONE) : (cur_x_q + ONE);
                        end
                        if (step_y) begin
                            cur_y_d = sy_neg_q ? (cur_y_q - ONE) : (cur_y_q + ONE);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pix_x     = cur_x_q;
    assign pix_y     = cur_y_q;
    assign pix_valid = (state_q == S_RUN) && on_screen;
    assign busy      = (state_q != S_IDLE);
    assign ldone     = (state_q == S_DONE);

endmodule

// File: tb/tb_line_rasterizer.sv
// tb/tb_line_rasterizer.sv - scoreboard bench for line_rasterizer with directed line vectors.
module tb_line_rasterizer;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [CW-1:0] pix_x, pix_y;
    logic          pix_valid, busy, ldone;
    logic          pix_ready = 1'b1;

    int total = 0;
    int bad = 0;
    int n_xfer = 0;
    int cyc = 0;
    int ready_mode = 0;
    logic [2*CW:0] exp_q[$];
    logic          stall_q = 1'b0;
    logic [CW-1:0] hold_x = '0, hold_y = '0;

    line_rasterizer #(.COORD_W(CW), .SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk(clk), .nreset(nreset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .busy(busy), .ldone(ldone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Ready pattern 1,0,0,1 repeating in mode 1.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) pix_ready = 1'b1;
            else pix_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        end
    end

    always @(negedge clk) begin
        if (!nreset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_hold_valid", pix_valid, 1);
                check("stall_hold_xy", {pix_x, pix_y}, {hold_x, hold_y});
            end
            stall_q = pix_valid && !pix_ready;
            hold_x  = pix_x;
            hold_y  = pix_y;
            if (pix_valid && ldone) check("valid_with_ldone", 1, 0);
            if (pix_valid && pix_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) check("unexpected_pixel", {pix_x, pix_y}, 32'hFFFF_FFFF);
                else check("pixel", {1'b0, pix_x, pix_y}, exp_q.pop_front());
            end
            if (ldone) begin
                if (exp_q.size() == 0) check("unexpected_ldone", 1, 0);
                else check("ldone_order", {1'b1, 20'd0}, exp_q.pop_front());
            end
        end
    end

    task automatic push_px(input int x, input int y);
        exp_q.push_back({1'b0, CW'(x), CW'(y)});
    endtask

    task automatic push_done();
        exp_q.push_back({1'b1, 20'd0});
    endtask

    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1);
        @(posedge clk);
        #1;
        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_complete"}, (exp_q.size() == 0) && !busy, 1);
        repeat (4) @(negedge clk);
        check({name, "_quiet"}, {busy, pix_valid, ldone}, 0);
        check({name, "_queue"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wn;
        repeat (2) @(negedge clk);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ldone", ldone, 0);
        check("rst_pix_xy", {pix_x, pix_y}, 0);
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // Horizontal line with exact cycle timing.
        for (int i = 0; i <= 4; i++) push_px(i, 0);
        push_done();
        issue(0, 0, 4, 0);
        @(negedge clk);
        check("t1_setup_valid", pix_valid, 0);
        check("t1_setup_busy", busy, 1);
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            check("t1_consecutive_valid", pix_valid, 1);
        end
        @(negedge clk);
        check("t1_ldone", ldone, 1);
        check("t1_busy_in_done", busy, 1);
        @(negedge clk);
        check("t1_busy_low", busy, 0);
        check("t1_ldone_low", ldone, 0);
        wait_idle("t1");

        // Steep line, negative in both axes.
        push_px(3, 5); push_px(3, 4); push_px(2, 3);
        push_px(2, 2); push_px(1, 1); push_px(1, 0);
        push_done();
        issue(3, 5, 1, 0);
        wait_idle("t2");

        // Diagonal with back-pressure.
        ready_mode = 1;
        for (int i = 0; i <= 3; i++) push_px(i, i);
        push_done();
        issue(0, 0, 3, 3);
        wait_idle("t3");
        ready_mode = 0;

        // Degenerate single point.
        push_px(7, 7);
        push_done();
        issue(7, 7, 7, 7);
        wait_idle("t4");

        // Second start mid-line must be ignored.
        for (int i = 0; i <= 9; i++) push_px(i, 0);
        push_done();
        issue(0, 0, 9, 0);
        repeat (3) @(posedge clk);
        #1;
        x0 = 5; y0 = 5; x1 = 6; y1 = 6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("t5");

        // Reset after three transfers abandons the line.
        for (int i = 0; i <= 9; i++) push_px(i, 0);
        push_done();
        wn = n_xfer;
        issue(0, 0, 9, 0);
        for (int n = 0; n < 50 && (n_xfer - wn) < 3; n++) @(negedge clk);
        check("t6_three_xfers", n_xfer - wn, 3);
        @(posedge clk);
        #2;
        nreset = 1'b0;
        #1;
        check("t6_rst_valid", pix_valid, 0);
        check("t6_rst_xy", {pix_x, pix_y}, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ldone", ldone, 0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check("t6_rst_no_ldone", ldone, 0);
        end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(negedge clk);
        check("t6_after_rst_idle", busy, 0);

        // Fresh leftward horizontal line after reset.
        push_px(2, 1); push_px(1, 1); push_px(0, 1);
        push_done();
        issue(2, 1, 0, 1);
        @(negedge clk);
        check("t7_setup_valid", pix_valid, 0);
        @(negedge clk);
        check("t7_first_valid", pix_valid, 1);
        wait_idle("t7");

        // Vertical line upward.
        push_px(4, 2); push_px(4, 1); push_px(4, 0);
        push_done();
        issue(4, 2, 4, 0);
        wait_idle("t8");

`ifdef LINE_CLIP_EN
        push_px(637, 0); push_px(638, 0); push_px(639, 0);
        push_done();
        issue(637, 0, 642, 0);
        wait_idle("t9_clip");
        push_done();
        issue(700, 10, 705, 12);
        wait_idle("t10_offscreen");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
